// File: rtl/isram_axil_slave.sv
// ---------------------------------------------------------------------------
// isram_axil_slave
// Read-only AXI4-Lite instruction SRAM slave (AR/R channels only) placed in
// front of the instruction fetch unit. Each accepted read waits a fixed or
// LFSR-chosen number of cycles before the response. This gives the fetch FSM
// variable latency. A side-band preload port loads program images directly.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   araddr/arvalid    read address channel (byte address)
//   arready           high in IDLE; low while a transaction is outstanding
//   rdata/rresp       read data and response (00 OKAY, 10 SLVERR, 11 DECERR)
//   rvalid/rready     read data channel handshake
//   init_we/addr/data preload write into the word array (any FSM state)
// ---------------------------------------------------------------------------
module isram_axil_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 4096,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    RAND_DELAY  = 1,
  parameter int                    FIXED_DELAY = 2,
  parameter int                    DELAY_BITS  = 3,
  parameter logic [7:0]            LFSR_SEED   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     init_we,
  input  logic [$clog2(DEPTH)-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0]    init_data
);

  localparam int AW = $clog2(DEPTH);
  // Counter must hold both FIXED_DELAY (up to 15) and the random field.
  localparam int CW = (DELAY_BITS > 4) ? DELAY_BITS : 4;
  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(DEPTH);
  localparam logic [CW-1:0]         FIXED_W = CW'(FIXED_DELAY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Fibonacci LFSR step, taps 8,6,5,4 (bit n is lfsr[n-1]); never reaches 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    lfsr_next = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] word_off_s;
  logic                  misaligned_s;
  logic                  out_of_range_s;
  logic [CW-1:0]         delay_load_s;

  // Address decode of the latched request; range check works on the word
  // offset so BASE_ADDR + 4*DEPTH never has to be formed (no overflow).
  always_comb begin
    word_off_s     = (addr_q - BASE_ADDR) >> 2;
    misaligned_s   = (addr_q[1:0] != 2'b00);
    out_of_range_s = (addr_q < BASE_ADDR) || (word_off_s >= DEPTH_W);
    if (RAND_DELAY != 0) begin
      delay_load_s = CW'(lfsr_q[DELAY_BITS-1:0]);
    end else begin
      delay_load_s = FIXED_W;
    end
  end

  // Next-state logic for the IDLE -> DELAY -> RESP transaction FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    lfsr_d    = lfsr_next(lfsr_q);
    case (state_q)
      S_IDLE: begin
        // arready_q is low only on the first cycle out of reset.
        if (arready_q && arvalid) begin
          addr_d    = araddr;
          arready_d = 1'b0;
          cnt_d     = delay_load_s;
          state_d   = S_DELAY;
        end else begin
          arready_d = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q == {CW{1'b0}}) begin
          rvalid_d = 1'b1;
          state_d  = S_RESP;
          if (misaligned_s) begin
            rresp_d = 2'b10;
            rdata_d = {DATA_WIDTH{1'b0}};
          end else if (out_of_range_s) begin
            rresp_d = 2'b11;
            rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            rresp_d = 2'b00;
            rdata_d = mem[word_off_s[AW-1:0]];
          end
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          rdata_d   = {DATA_WIDTH{1'b0}};
          rresp_d   = 2'b00;
          arready_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = {DATA_WIDTH{1'b0}};
        rresp_d   = 2'b00;
        cnt_d     = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      lfsr_q    <= LFSR_SEED;
      addr_q    <= {DATA_WIDTH{1'b0}};
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      addr_q    <= addr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Preload port; the array is not reset. A read on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_isram_axil_slave.sv
// Bench for isram_axil_slave. Three instances share clk/rst:
//   dut0: fixed delay 0, dut1: fixed delay 3, dut2: LFSR delay.
// A transaction-level model predicts arready/rvalid/rdata/rresp for every
// cycle; directed sequences add hand-computed literal expectations.
module tb_isram_axil_slave;
  localparam int          N     = 3;
  localparam int          DEPTH = 4096;
  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr    [N];
  logic        arvalid   [N];
  logic        arready   [N];
  logic [31:0] rdata     [N];
  logic [1:0]  rresp     [N];
  logic        rvalid    [N];
  logic        rready    [N];
  logic        init_we   [N];
  logic [AW-1:0] init_addr [N];
  logic [31:0] init_data [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    isram_axil_slave #(
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH),
      .BASE_ADDR  (BASE),
      .RAND_DELAY ((g == 2) ? 1 : 0),
      .FIXED_DELAY((g == 1) ? 3 : 0),
      .DELAY_BITS (3),
      .LFSR_SEED  (8'hA5)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .araddr   (araddr[g]),
      .arvalid  (arvalid[g]),
      .arready  (arready[g]),
      .rdata    (rdata[g]),
      .rresp    (rresp[g]),
      .rvalid   (rvalid[g]),
      .rready   (rready[g]),
      .init_we  (init_we[g]),
      .init_addr(init_addr[g]),
      .init_data(init_data[g])
    );
  end

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [N][DEPTH];
  logic [7:0]  m_lfsr;
  longint      edge_cnt;
  logic        model_on = 1'b0;
  logic        m_out    [N];
  logic [31:0] m_addr   [N];
  longint      m_due    [N];
  logic        exp_ar   [N];
  logic        exp_rv   [N];
  logic [31:0] exp_data [N];
  logic [1:0]  exp_resp [N];

  function automatic logic [1:0] expect_resp(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = 64'(a);
    lo = 64'(BASE);
    hi = lo + 64'(4 * DEPTH);
    if (a[1:0] != 2'b00) return 2'b10;
    if (la < lo || la >= hi) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] expect_data(input int i, input logic [31:0] a);
    int idx;
    if (expect_resp(a) != 2'b00) return 32'h0;
    idx = int'((a - BASE) >> 2);
    return m_mem[i][idx];
  endfunction

  function automatic longint delay_of(input int i);
    logic [7:0] l;
    l = m_lfsr;
    if (i == 2) return longint'(l[2:0]);
    else if (i == 1) return 64'd3;
    else return 64'd0;
  endfunction

  // Model memory: nonblocking so same-edge reads see the old word.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (init_we[i]) m_mem[i][init_addr[i]] <= init_data[i];
    end
  end

  // Transaction model: a request is due a fixed number of edges after its handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_on <= 1'b1;
      m_lfsr   <= 8'hA5;
      edge_cnt <= 0;
      for (int i = 0; i < N; i++) begin
        m_out[i] <= 1'b0; m_addr[i] <= 32'h0; m_due[i] <= 0;
        exp_ar[i] <= 1'b0; exp_rv[i] <= 1'b0; exp_data[i] <= 32'h0; exp_resp[i] <= 2'b00;
      end
    end else begin
      m_lfsr   <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      edge_cnt <= edge_cnt + 1;
      for (int i = 0; i < N; i++) begin
        if (exp_rv[i]) begin
          if (rready[i]) begin
            exp_rv[i] <= 1'b0; exp_data[i] <= 32'h0; exp_resp[i] <= 2'b00;
            m_out[i] <= 1'b0; exp_ar[i] <= 1'b1;
          end
        end else if (m_out[i]) begin
          if (edge_cnt == m_due[i]) begin
            exp_rv[i]   <= 1'b1;
            exp_data[i] <= expect_data(i, m_addr[i]);
            exp_resp[i] <= expect_resp(m_addr[i]);
          end
        end else if (exp_ar[i] && arvalid[i]) begin
          m_out[i]  <= 1'b1;
          m_addr[i] <= araddr[i];
          m_due[i]  <= edge_cnt + 1 + delay_of(i);
          exp_ar[i] <= 1'b0;
        end else begin
          exp_ar[i] <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < N; i++) begin
        check("arready", i, 32'(arready[i]), 32'(exp_ar[i]));
        check("rvalid",  i, 32'(rvalid[i]),  32'(exp_rv[i]));
        check("rdata",   i, rdata[i],        exp_data[i]);
        check("rresp",   i, 32'(rresp[i]),   32'(exp_resp[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input int i, input int idx, input logic [31:0] d);
    init_we[i] = 1'b1; init_addr[i] = AW'(idx); init_data[i] = d;
    @(posedge clk); #2;
    init_we[i] = 1'b0;
  endtask

  // One complete read; called 2 time units after an edge, returns at the same phase.
  task automatic fetch(input int i, input logic [31:0] addr, input int stall,
                       input logic [31:0] exp_d, input logic [1:0] exp_r, output int lat);
    logic hs, ar_was;
    araddr[i] = addr; arvalid[i] = 1'b1; rready[i] = (stall == 0);
    hs = 1'b0;
    for (int n = 0; n < 20 && !hs; n++) begin
      ar_was = arready[i];
      @(posedge clk); #2;
      hs = ar_was;
    end
    arvalid[i] = 1'b0; araddr[i] = 32'h0;
    lat = 0;
    check("handshake", i, 32'(hs), 32'd1);
    if (!hs) return;
    while (rvalid[i] !== 1'b1 && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    check("rvalid_seen", i, 32'(rvalid[i]), 32'd1);
    check("fetch_rdata", i, rdata[i], exp_d);
    check("fetch_rresp", i, 32'(rresp[i]), 32'(exp_r));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #2;
      check("hold_rvalid",  i, 32'(rvalid[i]),  32'd1);
      check("hold_rdata",   i, rdata[i],        exp_d);
      check("hold_rresp",   i, 32'(rresp[i]),   32'(exp_r));
      check("hold_arready", i, 32'(arready[i]), 32'd0);
    end
    rready[i] = 1'b1;
    @(posedge clk); #2;
    rready[i] = 1'b0;
    check("done_rvalid",  i, 32'(rvalid[i]),  32'd0);
    check("done_arready", i, 32'(arready[i]), 32'd1);
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'h1357_0000 + 32'(k) * 32'h0000_1011;
  endfunction

  initial begin
    int lat;
    int nd;
    logic seen [9];
    for (int i = 0; i < N; i++) begin
      araddr[i] = 32'h0; arvalid[i] = 1'b0; rready[i] = 1'b0;
      init_we[i] = 1'b0; init_addr[i] = '0; init_data[i] = 32'h0;
    end
    for (int l = 0; l < 9; l++) seen[l] = 1'b0;
    #1 rst = 1'b1;

    // Preload while in reset (the array ignores rst).
    preload(0, 0, 32'h0000_0413);
    preload(0, DEPTH - 1, 32'hDEAD_BEEF);
    preload(1, 1, 32'h1234_5678);
    preload(1, 5, 32'h1111_1111);
    preload(1, 7, 32'hCAFE_F00D);
    for (int k = 0; k < 200; k++) preload(2, k, pat(k));
    repeat (3) begin @(posedge clk); #2; end
    check("rst_arready", 0, 32'(arready[0]), 32'd0);
    check("rst_rvalid",  0, 32'(rvalid[0]),  32'd0);
    rst = 1'b0;
    check("rel_arready_pre", 0, 32'(arready[0]), 32'd0);
    @(posedge clk); #2;
    check("rel_arready", 0, 32'(arready[0]), 32'd1);
    check("rel_rvalid",  0, 32'(rvalid[0]),  32'd0);

    // Fixed delay 0: one-cycle latency.
    fetch(0, 32'h8000_0000, 0, 32'h0000_0413, 2'b00, lat);
    check("lat_fd0", 0, 32'(lat), 32'd1);

    // Fixed delay 3 with a five-cycle rready stall.
    fetch(1, 32'h8000_0004, 5, 32'h1234_5678, 2'b00, lat);
    check("lat_fd3", 1, 32'(lat), 32'd4);

    // Error responses and the last valid word.
    fetch(0, 32'h8000_0002, 0, 32'h0, 2'b10, lat);
    fetch(0, 32'h7FFF_FFFC, 0, 32'h0, 2'b11, lat);
    fetch(0, 32'h8000_4000, 0, 32'h0, 2'b11, lat);
    fetch(0, 32'h8000_3FFC, 0, 32'hDEAD_BEEF, 2'b00, lat);
    fetch(0, 32'hFFFF_FFFC, 0, 32'h0, 2'b11, lat);

    // Preload collision: handshake at edge N, array sampled at edge N+4.
    check("coll_arready", 1, 32'(arready[1]), 32'd1);
    araddr[1] = 32'h8000_0014; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(posedge clk); #2;
    arvalid[1] = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    init_we[1] = 1'b1; init_addr[1] = AW'(5); init_data[1] = 32'h2222_2222;
    @(posedge clk); #2;
    init_we[1] = 1'b0;
    check("coll_rvalid", 1, 32'(rvalid[1]), 32'd1);
    check("coll_old",    1, rdata[1],        32'h1111_1111);
    rready[1] = 1'b1;
    @(posedge clk); #2;
    rready[1] = 1'b0;
    fetch(1, 32'h8000_0014, 0, 32'h2222_2222, 2'b00, lat);

    // LFSR delay: 200 back-to-back sequential fetches.
    for (int k = 0; k < 200; k++) begin
      fetch(2, BASE + 32'(4 * k), 0, pat(k), 2'b00, lat);
      check("lat_range", 2, 32'(lat >= 1 && lat <= 8), 32'd1);
      if (lat >= 1 && lat <= 8) seen[lat] = 1'b1;
    end
    nd = 0;
    for (int l = 1; l <= 8; l++) if (seen[l]) nd++;
    check("distinct_lat", 2, 32'(nd >= 4), 32'd1);

    // Reset while in DELAY.
    check("rd_arready", 1, 32'(arready[1]), 32'd1);
    araddr[1] = 32'h8000_001C; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(posedge clk); #2;
    arvalid[1] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("rd_rvalid",  1, 32'(rvalid[1]),  32'd0);
    check("rd_arready0", 1, 32'(arready[1]), 32'd0);
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    @(posedge clk); #2;
    check("rd_rel_arready", 1, 32'(arready[1]), 32'd1);

    // Reset while in RESP with rready low.
    araddr[1] = 32'h8000_001C; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(posedge clk); #2;
    arvalid[1] = 1'b0;
    for (int n = 0; n < 20 && rvalid[1] !== 1'b1; n++) begin @(posedge clk); #2; end
    check("rr_rvalid_pre", 1, 32'(rvalid[1]), 32'd1);
    check("rr_rdata_pre",  1, rdata[1],       32'hCAFE_F00D);
    rst = 1'b1; #1;
    check("rr_rvalid", 1, 32'(rvalid[1]), 32'd0);
    check("rr_rdata",  1, rdata[1],       32'h0);
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    @(posedge clk); #2;
    check("rr_rel_arready", 1, 32'(arready[1]), 32'd1);
    fetch(1, 32'h8000_001C, 0, 32'hCAFE_F00D, 2'b00, lat);
    check("lat_after_rst", 1, 32'(lat), 32'd4);

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
